// File: rtl/dmux_rr_sched_pkg.sv
// Shared types for the round-robin demux scheduler: FSM encoding,
// channel count and the one-hot grant helper.
package dmux_rr_sched_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_e;

  function automatic logic [NUM_CH-1:0] onehot4(input logic [1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/dmux_rr_sched_pick.sv
// Combinational round-robin picker: first requester after ptr, searching
// ptr+1, ptr+2, ... modulo 4.
module rr_pick4
  import dmux_rr_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] ireq,
  input  logic [1:0]        ptr,
  output logic [1:0]        winner,
  output logic              found
);

  always_comb begin
    // NOTE: every output gets a default first, so no path through the block leaves it unassigned and no latch is inferred.
    winner = ptr;
    found  = 1'b0;
    // Walk from the lowest priority up so the closest requester after ptr wins last.
    for (int i = NUM_CH; i >= 1; i--) begin
      if (ireq[ptr + 2'(i)]) begin
        winner = ptr + 2'(i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmux_rr_sched.sv
// Round-robin scheduler sharing one serial source among four demux consumers,
// in fixed-length valid/ready bursts with a turnaround cycle between bursts.
module dmux_rr_sched
  import dmux_rr_sched_pkg::*;
#(
  parameter int BURST = 4,
  parameter int CW    = 4
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic [NUM_CH-1:0] ireq,
  input  logic              ivalid,
  input  logic              idata,
  output logic              oready,
  output logic [1:0]        osel,
  output logic              oic,
  output logic [NUM_CH-1:0] ogrant,
  output logic              odone,
  output logic              obusy
);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    sel_q, sel_d;
  logic          done_q, done_d;

  logic [1:0]    winner;
  logic          found;

  rr_pick4 u_pick (
    .ireq   (ireq),
    .ptr    (ptr_q),
    .winner (winner),
    .found  (found)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_XFER;
          sel_d   = winner;
          cnt_d   = '0;
        end
      end
      S_XFER: begin
        if (ivalid) cnt_d = cnt_q + CW'(1);
        // A dropped request ends the burst silently, even on the final beat.
        if (!ireq[sel_q] || (ivalid && cnt_q == LAST_BEAT)) begin
          state_d = S_IDLE;
          ptr_d   = sel_q;
          cnt_d   = '0;
          done_d  = ireq[sel_q];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    oready = 1'b0;
    obusy  = 1'b0;
    ogrant = '0;
    oic    = 1'b0;
    osel   = sel_q;
    odone  = done_q;
    if (state_q == S_XFER) begin
      oready = 1'b1;
      obusy  = 1'b1;
      ogrant = onehot4(sel_q);
      oic    = idata & ivalid;
    end
  end

endmodule

// File: tb/tb_dmux_rr_sched.sv
// Bench for dmux_rr_sched: BURST=4 and BURST=1 instances on shared stimulus,
// each feeding a behavioural 1-to-4 demux, checked against a burst-level model.
module tb_dmux_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ireq = '0;
  logic       ivalid = 1'b0;
  logic       idata = 1'b0;

  logic       a_ready, a_done, a_ic, a_busy, b_ready, b_done, b_ic, b_busy;
  logic [1:0] a_sel, b_sel;
  logic [3:0] a_grant, b_grant;
  logic [3:0] a_oz, b_oz;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmux_rr_sched #(.BURST(4), .CW(4)) u_a (
    .iclk(clk), .irst_n(rst_n), .ireq(ireq), .ivalid(ivalid), .idata(idata),
    .oready(a_ready), .osel(a_sel), .oic(a_ic), .ogrant(a_grant),
    .odone(a_done), .obusy(a_busy)
  );

  dmux_rr_sched #(.BURST(1), .CW(1)) u_b (
    .iclk(clk), .irst_n(rst_n), .ireq(ireq), .ivalid(ivalid), .idata(idata),
    .oready(b_ready), .osel(b_sel), .oic(b_ic), .ogrant(b_grant),
    .odone(b_done), .obusy(b_busy)
  );

  // Downstream 1-to-4 demux: oz(k) follows ic only when the selects address k.
  assign a_oz = {a_sel == 2'd3 && a_ic, a_sel == 2'd2 && a_ic, a_sel == 2'd1 && a_ic, a_sel == 2'd0 && a_ic};
  assign b_oz = {b_sel == 2'd3 && b_ic, b_sel == 2'd2 && b_ic, b_sel == 2'd1 && b_ic, b_sel == 2'd0 && b_ic};

  // Burst-level reference model, one slot per instance.
  int m_owner[2];
  int m_beats[2];
  int m_ptr[2];
  int m_sel[2];
  int m_done[2];
  int m_burst[2] = '{4, 1};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = -1; m_beats[i] = 0; m_ptr[i] = 3; m_sel[i] = 0; m_done[i] = 0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int nd = 0;
      if (m_owner[i] < 0) begin
        for (int k = 1; k <= 4; k++) begin
          int c = (m_ptr[i] + k) % 4;
          if (ireq[c] && m_owner[i] < 0) begin
            m_owner[i] = c; m_sel[i] = c; m_beats[i] = 0;
          end
        end
      end else begin
        if (ivalid) m_beats[i]++;
        if (!ireq[m_owner[i]]) begin
          m_ptr[i] = m_owner[i]; m_owner[i] = -1;
        end else if (m_beats[i] == m_burst[i]) begin
          m_ptr[i] = m_owner[i]; m_owner[i] = -1; nd = 1;
        end
      end
      m_done[i] = nd;
    end
  endtask

  // Packed {ready, busy, done, ic, sel, grant}
  function automatic logic [9:0] model_out(input int i);
    logic act = (m_owner[i] >= 0);
    logic [3:0] g = act ? (4'b0001 << m_owner[i]) : 4'b0000;
    return {act, act, m_done[i] != 0, act && ivalid && idata, 2'(m_sel[i]), g};
  endfunction

  function automatic logic [9:0] dut_out(input int i);
    if (i == 0) return {a_ready, a_busy, a_done, a_ic, a_sel, a_grant};
    return {b_ready, b_busy, b_done, b_ic, b_sel, b_grant};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs and compare both instances at the falling edge.
  task automatic sample(input logic [3:0] r, input logic v, input logic d);
    ireq = r; ivalid = v; idata = d;
    @(negedge clk);
    check("model_a", 32'(dut_out(0)), 32'(model_out(0)));
    check("model_b", 32'(dut_out(1)), 32'(model_out(1)));
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    ireq = '0; ivalid = 1'b0; idata = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    advance();
  endtask

  typedef struct {
    logic [3:0] req;
    logic       v;
    logic       d;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       ready;
    logic       done;
    logic [3:0] oz;
  } vec_t;

  vec_t tbl[7];
  logic [3:0] starts[$];
  logic [3:0] exp_rr[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] exp_b1[4] = '{4'b0001, 4'b1000, 4'b0001, 4'b1000};

  initial begin
    int cnt;
    int ndone;
    logic prev;

    model_reset();
    #12;
    check("reset_a", 32'({a_ready, a_busy, a_done, a_ic, a_sel, a_grant}), 32'd0);
    check("reset_b", 32'({b_ready, b_busy, b_done, b_ic, b_sel, b_grant}), 32'd0);

    // Single requester on channel 2, BURST=4 instance.
    tbl[0] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000};
    tbl[1] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100};
    tbl[2] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100};
    tbl[3] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100};
    tbl[4] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100};
    tbl[5] = '{4'b0100, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 4'b0000};
    tbl[6] = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 4'b0100};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sample(tbl[i].req, tbl[i].v, tbl[i].d);
      check($sformatf("t1_row%0d", i), 32'({a_grant, a_sel, a_ready, a_done, a_oz}),
            32'({tbl[i].grant, tbl[i].sel, tbl[i].ready, tbl[i].done, tbl[i].oz}));
      advance();
    end

    // All four requesting: grant order 0,1,2,3,0.
    do_reset();
    starts.delete();
    prev = 1'b0;
    for (int c = 0; c < 40 && starts.size() < 5; c++) begin
      sample(4'b1111, 1'b1, 1'($urandom_range(0, 1)));
      if (a_ready && !prev) starts.push_back(a_grant);
      prev = a_ready;
      advance();
    end
    check("t2_nstarts", 32'(starts.size()), 32'd5);
    for (int i = 0; i < 5 && i < starts.size(); i++)
      check($sformatf("t2_grant%0d", i), 32'(starts[i]), 32'(exp_rr[i]));

    // Channel 1 with ivalid toggling: 4 beats stretch over 8 ready cycles.
    do_reset();
    cnt = 0;
    ndone = 0;
    for (int c = 0; c < 30 && ndone == 0; c++) begin
      sample(4'b0010, 1'(c % 2 == 0), 1'b1);
      if (a_ready) cnt++;
      if (a_done) ndone++;
      advance();
    end
    check("t3_len", 32'(cnt), 32'd8);

    // Abort: channel 3 drops after 2 beats, next search starts at channel 0.
    do_reset();
    sample(4'b1000, 1'b1, 1'b1); advance();
    sample(4'b1000, 1'b1, 1'b1);
    check("t4_grant3", 32'(a_grant), 32'b1000);
    advance();
    sample(4'b1000, 1'b1, 1'b1); advance();
    sample(4'b0011, 1'b1, 1'b1); advance();
    sample(4'b0011, 1'b1, 1'b1);
    check("t4_idle", 32'({a_ready, a_done}), 32'd0);
    advance();
    sample(4'b0011, 1'b1, 1'b1);
    check("t4_next", 32'(a_grant), 32'b0001);
    advance();

    // Asynchronous reset between clock edges in the middle of a burst.
    do_reset();
    sample(4'b0100, 1'b1, 1'b1); advance();
    sample(4'b0100, 1'b1, 1'b1); advance();
    #2 rst_n = 1'b0;
    #1;
    check("t5_async", 32'({a_grant, a_ready, a_ic, a_sel}), 32'd0);
    model_reset();
    ireq = '0;
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    sample(4'b1010, 1'b1, 1'b1); advance();
    sample(4'b1010, 1'b1, 1'b1);
    check("t5_first", 32'(a_grant), 32'b0010);
    advance();

    // BURST=1 instance with channels 0 and 3: alternate single-beat bursts.
    do_reset();
    starts.delete();
    ndone = 0;
    prev = 1'b0;
    for (int c = 0; c < 9; c++) begin
      sample(4'b1001, 1'b1, 1'b1);
      if (b_ready && !prev) starts.push_back(b_grant);
      if (b_done) ndone++;
      prev = b_ready;
      advance();
    end
    check("t6_nstarts", 32'(starts.size()), 32'd4);
    check("t6_ndone", 32'(ndone), 32'd4);
    for (int i = 0; i < 4 && i < starts.size(); i++)
      check($sformatf("t6_grant%0d", i), 32'(starts[i]), 32'(exp_b1[i]));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      r = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) r = 4'b0000;
      sample(r, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)));
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmux_rr_sched.md
Name: dmux_rr_sched

Overview:
Round-robin scheduler that shares one serial source among four consumers through the existing 1-to-4 demultiplexer (data in ic, selects is1/is0, outputs oz0..oz3).
- Arbitrates four channel requests.
- Drives the demux select lines.
- Gates source data onto ic.
- Paces transfers with a valid/ready handshake in fixed-length bursts.
- Sits between the source and the demux; the demux stays purely combinational.

Parameters:
BURST, 4, beats per granted burst; legal range 1..16.
CW, 4, beat-counter width; must satisfy 2^CW >= BURST.

Ports:
iclk  input  1  system clock, all state on rising edge
irst_n  input  1  asynchronous active-low reset
ireq  input  4  per-channel request; bit k = consumer on oz(k) wants data
ivalid  input  1  source presents a valid beat on idata
idata  input  1  source data bit
oready  output  1  scheduler accepts a beat this cycle (beat transfers when ivalid & oready)
osel  output  2  demux select; osel[1] -> is1, osel[0] -> is0
oic  output  1  gated data to demux ic
ogrant  output  4  one-hot current grant, all-zero when idle
odone  output  1  one-cycle pulse on the cycle after the final beat of a completed burst
obusy  output  1  high while a burst is in progress

Behaviour:
Reset (irst_n low, asynchronous, takes effect immediately, including mid-burst):
- State IDLE; beat counter 0; round-robin pointer 3, so channel 0 has highest priority first.
- oready=0, osel=00, oic=0, ogrant=0000, odone=0, obusy=0.

States: IDLE, XFER. Encode as 1 bit.

IDLE:
- oready=0, ogrant=0000, obusy=0.
- osel holds the last granted index (00 after reset).
- If ireq != 0 at a rising edge, pick winner w = first set bit searching ptr+1, ptr+2, ... modulo 4.
- Register w into osel and ogrant, clear the counter, go to XFER.
- Grant latency: one cycle from the request being sampled.

XFER:
- oready=1, obusy=1, ogrant=onehot(w), osel=w.
- oic = idata & ivalid, combinational; 0 in IDLE.
- Each edge with ivalid=1 increments the counter.
- Edge with ivalid=1 and counter==BURST-1: go IDLE, ptr<=w, odone pulses high for the next cycle.
- ivalid=0: no beat; counter and state hold indefinitely.

Abort:
- If ireq[w] is low at an edge in XFER, go IDLE, ptr<=w, no odone.
- The beat is still counted as transferred if ivalid=1 on that edge.
- Abort takes priority over completion only for odone: if ireq[w] drops on the final beat, odone is still 0.

Turnaround:
- At least one IDLE cycle (oready=0) between consecutive bursts, even when re-granting the same channel.

Fairness:
- Under continuous requests from all four channels, the grant order is 0,1,2,3,0,...
- A lone requester is re-granted after every turnaround.

Other rules:
- Requests arriving mid-burst are ignored until IDLE.
- BURST=1: every accepted beat ends the burst.
- Counter never exceeds BURST-1; no wrap inside a burst.

Decomposition:
- Shared header dmux_defs.vh: state encodings S_IDLE/S_XFER and the channel count 4.
- One natural sub-module, rr_pick4 (combinational): inputs ireq[3:0] and ptr[1:0]; outputs winner[1:0] and a found flag.
- The FSM, counter and gating stay in dmux_rr_sched.
- The top-level bench instantiates dmux_rr_sched feeding the existing dmux1_4 so osel/oic route visibly to oz0..oz3.

Test Plan:
1. Reset then ireq=0100, ivalid=1, idata=1 constant, BURST=4 -> ogrant=0100 and osel=10 one cycle after the request; oz2=1 for exactly 4 cycles; odone pulse on the following cycle; oready low one cycle.
2. ireq=1111 held, ivalid=1 -> bursts granted to channels 0,1,2,3,0 in order, each 4 beats, one idle cycle between; osel sequence 00,01,10,11,00.
3. ireq=0010, ivalid toggling 1,0,1,0... -> burst lasts 8 cycles (4 beats); counter holds on ivalid=0 cycles; oic=0 whenever ivalid=0.
4. Grant channel 3, drop ireq[3] after 2 beats -> IDLE next edge; no odone; next grant among remaining requesters starts searching at channel 0.
5. Assert irst_n=0 asynchronously mid-burst (between clock edges) -> ogrant=0000, oready=0, oic=0, osel=00 immediately; after release the first grant goes to the lowest-index requester.
6. BURST=1, ireq=1001, ivalid=1 -> grants alternate 0,3,0,3 with single-beat bursts, an idle cycle between each, and odone after every burst.
